// File: rtl/alu_issue_pkg.sv
// Shared types for alu_issue_seq: instruction layout, FSM states, ALU operation
// codes and the instruction-opcode to ALU-operation mapping.
package alu_issue_pkg;

    localparam int NREGS   = 8;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int ALUOP_W = 5;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_OR  = 4'h1,
        OP_NOT = 4'h2,
        OP_XOR = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_PAR = 4'h6,
        OP_LSL = 4'h8,
        OP_LSR = 4'h9,
        OP_CMP = 4'hA
    } opcode_e;

    localparam logic [ALUOP_W-1:0] ALU_AND     = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALU_OR      = 5'b00001;
    localparam logic [ALUOP_W-1:0] ALU_NOT     = 5'b00010;
    localparam logic [ALUOP_W-1:0] ALU_XOR     = 5'b00011;
    localparam logic [ALUOP_W-1:0] ALU_ADD     = 5'b00100;
    localparam logic [ALUOP_W-1:0] ALU_SUB     = 5'b00101;
    localparam logic [ALUOP_W-1:0] ALU_PAR     = 5'b00110;
    localparam logic [ALUOP_W-1:0] ALU_LSL     = 5'b10000;
    localparam logic [ALUOP_W-1:0] ALU_LSR     = 5'b10001;
    localparam logic [ALUOP_W-1:0] ALU_ILLEGAL = 5'b11111;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
    } instr_t;

    // CMP reuses the subtractor purely for its compare flags.
    function automatic logic [ALUOP_W-1:0] map_op(input logic [3:0] op);
        logic [ALUOP_W-1:0] alu;
        case (op)
            OP_AND:  alu = ALU_AND;
            OP_OR:   alu = ALU_OR;
            OP_NOT:  alu = ALU_NOT;
            OP_XOR:  alu = ALU_XOR;
            OP_ADD:  alu = ALU_ADD;
            OP_SUB:  alu = ALU_SUB;
            OP_PAR:  alu = ALU_PAR;
            OP_LSL:  alu = ALU_LSL;
            OP_LSR:  alu = ALU_LSR;
            OP_CMP:  alu = ALU_SUB;
            default: alu = ALU_ILLEGAL;
        endcase
        return alu;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return map_op(op) != ALU_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x8 register file for alu_issue_seq: two operand read ports, a debug read
// port, and writeback plus external preload writes (writeback wins on a clash).
module alu_issue_regfile
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pre_en,
    input  logic [ADDR_W-1:0] pre_addr,
    input  logic [DATA_W-1:0] pre_data
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Writeback is applied last so it overrides a preload to the same address.
    always_comb begin
        mem_d = mem_q;
        if (pre_en) mem_d[pre_addr] = pre_data;
        if (wb_en)  mem_d[wb_addr]  = wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1_data = mem_q[rd1_addr];
    assign rd2_data = mem_q[rd2_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Four-state decode/issue sequencer driving an external 8-bit combinational ALU.
// Optional feature: `ALU_ISSUE_ILLEGAL_TRAP_EN traps illegal opcodes (sticky flag, no commit).
module alu_issue_seq
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [12:0] instr,
    output logic        instr_ready,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [4:0]  alu_op,
    input  logic [7:0]  alu_out,
    input  logic        alu_equal,
    input  logic        alu_less,
    input  logic        reg_wr_en,
    input  logic [2:0]  reg_wr_addr,
    input  logic [7:0]  reg_wr_data,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic        flag_eq,
    output logic        flag_lt,
    output logic        done,
    output logic        illegal
);

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d;
    logic [4:0]        op_q, op_d;
    logic              eq_q, eq_d, lt_q, lt_d;
    logic              flag_eq_q, flag_eq_d, flag_lt_q, flag_lt_d;
    logic              done_q, done_d, illegal_q, illegal_d;
    logic              wb_en;
    logic [DATA_W-1:0] rd1_data, rd2_data;

    alu_issue_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_addr (instr_q.rs1),
        .rd1_data (rd1_data),
        .rd2_addr (instr_q.rs2),
        .rd2_data (rd2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_en    (wb_en),
        .wb_addr  (instr_q.rd),
        .wb_data  (res_q),
        .pre_en   (reg_wr_en),
        .pre_addr (reg_wr_addr),
        .pre_data (reg_wr_data)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        op_d      = op_q;
        res_d     = res_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        flag_eq_d = flag_eq_q;
        flag_lt_d = flag_lt_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr_t'(instr);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                in1_d   = rd1_data;
                in2_d   = rd2_data;
                op_d    = map_op(instr_q.op);
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = alu_out;
                eq_d    = alu_equal;
                lt_d    = alu_less;
                done_d  = 1'b1;
                state_d = WB;
            end
            WB: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                if (!op_is_legal(instr_q.op)) begin
                    illegal_d = 1'b1;
                end else begin
                    flag_eq_d = eq_q;
                    flag_lt_d = lt_q;
                    wb_en     = (instr_q.op != OP_CMP);
                end
`else
                flag_eq_d = eq_q;
                flag_lt_d = lt_q;
                wb_en     = (instr_q.op != OP_CMP);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= '0;
            res_q     <= '0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
            op_q      <= op_d;
            res_q     <= res_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            flag_eq_q <= flag_eq_d;
            flag_lt_q <= flag_lt_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = rst_n && (state_q == IDLE);
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_op      = op_q;
    assign flag_eq     = flag_eq_q;
    assign flag_lt     = flag_lt_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: directed vector table, hand-written
// corner sequences and a randomized run against an instruction-level model.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [12:0] instr = '0;
    logic        instr_ready;
    logic [7:0]  alu_in1, alu_in2;
    logic [4:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_equal, alu_less;
    logic        reg_wr_en = 1'b0;
    logic [2:0]  reg_wr_addr = '0;
    logic [7:0]  reg_wr_data = '0;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;
    logic        flag_eq, flag_lt, done, illegal;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc[$];

    alu_issue_seq dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_op(alu_op), .alu_out(alu_out), .alu_equal(alu_equal),
        .alu_less(alu_less), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .flag_eq(flag_eq), .flag_lt(flag_lt), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_out = 8'hFF;
        case (alu_op)
            5'b00000: alu_out = alu_in1 & alu_in2;
            5'b00001: alu_out = alu_in1 | alu_in2;
            5'b00010: alu_out = ~alu_in1;
            5'b00011: alu_out = alu_in1 ^ alu_in2;
            5'b00100: alu_out = alu_in1 + alu_in2;
            5'b00101: alu_out = alu_in1 - alu_in2;
            5'b00110: alu_out = {7'd0, ^alu_in1};
            5'b10000: alu_out = alu_in1 << alu_in2;
            5'b10001: alu_out = alu_in1 >> alu_in2;
            default:  alu_out = 8'hFF;
        endcase
        alu_equal = (alu_in1 == alu_in2);
        alu_less  = (alu_in1 < alu_in2);
    end

    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready) acc_cyc.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2)};
    endfunction

    task automatic preload(input logic [2:0] addr, input logic [7:0] data);
        reg_wr_en = 1'b1; reg_wr_addr = addr; reg_wr_data = data;
        tick();
        reg_wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [7:0] data);
        dbg_addr = addr;
        #1;
        data = dbg_data;
    endtask

    // Issue one instruction and follow it to retirement, checking done latency.
    task automatic issue(input logic [12:0] ins, input bit coll_wb, input bit pre_dec,
                         output logic [4:0] op_seen);
        int n = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin tick(); n++; end
        check("accept_timeout", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        if (pre_dec) begin
            reg_wr_en = 1'b1; reg_wr_addr = ins[5:3]; reg_wr_data = 8'h11;
        end
        check("done_early", done, 1'b0);
        tick();
        reg_wr_en = 1'b0;
        op_seen = alu_op;
        tick();
        check("done_latency", done, 1'b1);
        if (coll_wb) begin
            reg_wr_en = 1'b1; reg_wr_addr = ins[8:6]; reg_wr_data = 8'h77;
        end
        tick();
        reg_wr_en = 1'b0;
        check("done_pulse_width", done, 1'b0);
    endtask

    // Instruction-level reference model.
    logic [7:0] m_reg [8];
    logic       m_eq, m_lt, m_ill;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_eq = 1'b0; m_lt = 1'b0; m_ill = 1'b0;
    endfunction

    function automatic void model_exec(input logic [12:0] ins);
        logic [3:0] op;
        logic [7:0] a, b, r;
        op = ins[12:9];
        a  = m_reg[ins[5:3]];
        b  = m_reg[ins[2:0]];
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = ~a;
            4'h3: r = a ^ b;
            4'h4: r = a + b;
            4'h5: r = a - b;
            4'h6: r = {7'd0, ^a};
            4'h8: r = (b >= 8) ? 8'h00 : 8'(a << b);
            4'h9: r = (b >= 8) ? 8'h00 : 8'(a >> b);
            4'hA: r = 8'h00;
            default: begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                m_ill = 1'b1;
                return;
`else
                r = 8'hFF;
`endif
            end
        endcase
        m_eq = (a == b);
        m_lt = (a < b);
        if (op != 4'hA) m_reg[ins[8:6]] = r;
    endfunction

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] a, b, pre, exp_rd;
        logic       exp_eq, exp_lt;
        logic [4:0] exp_aluop;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] v, v2;
        logic [4:0] op_seen;
        logic [12:0] ins;
        int n;

        vecs[0]  = '{"AND",   4'h0, 3'd3, 8'hCC, 8'hAA, 8'h5A, 8'h88, 1'b0, 1'b0, 5'b00000};
        vecs[1]  = '{"OR",    4'h1, 3'd3, 8'hCC, 8'hAA, 8'h5A, 8'hEE, 1'b0, 1'b0, 5'b00001};
        vecs[2]  = '{"NOT",   4'h2, 3'd3, 8'hCC, 8'hAA, 8'h5A, 8'h33, 1'b0, 1'b0, 5'b00010};
        vecs[3]  = '{"XOR",   4'h3, 3'd3, 8'hCC, 8'hAA, 8'h5A, 8'h66, 1'b0, 1'b0, 5'b00011};
        vecs[4]  = '{"ADD",   4'h4, 3'd3, 8'hF0, 8'h20, 8'h5A, 8'h10, 1'b0, 1'b0, 5'b00100};
        vecs[5]  = '{"SUB",   4'h5, 3'd3, 8'h09, 8'h05, 8'h5A, 8'h04, 1'b0, 1'b0, 5'b00101};
        vecs[6]  = '{"PAR",   4'h6, 3'd3, 8'h07, 8'h00, 8'h5A, 8'h01, 1'b0, 1'b0, 5'b00110};
        vecs[7]  = '{"LSL",   4'h8, 3'd3, 8'h03, 8'h02, 8'h5A, 8'h0C, 1'b0, 1'b0, 5'b10000};
        vecs[8]  = '{"LSR",   4'h9, 3'd3, 8'h80, 8'h09, 8'h5A, 8'h00, 1'b0, 1'b0, 5'b10001};
        vecs[9]  = '{"CMPlt", 4'hA, 3'd4, 8'h05, 8'h09, 8'hAA, 8'hAA, 1'b0, 1'b1, 5'b00101};
        vecs[10] = '{"CMPeq", 4'hA, 3'd4, 8'h33, 8'h33, 8'hAA, 8'hAA, 1'b1, 1'b0, 5'b00101};
        vecs[11] = '{"ADDeq", 4'h4, 3'd3, 8'h05, 8'h05, 8'h5A, 8'h0A, 1'b1, 1'b0, 5'b00100};
        vecs[12] = '{"SUBlt", 4'h5, 3'd3, 8'h05, 8'h09, 8'h5A, 8'hFC, 1'b0, 1'b1, 5'b00101};

        // Reset and idle
        tick();
        check("ready_in_reset", instr_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", instr_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check($sformatf("reset_R%0d", i), v, 8'h00);
        end
        check("reset_flag_eq", flag_eq, 1'b0);
        check("reset_flag_lt", flag_lt, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_illegal", illegal, 1'b0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            preload(3'd1, vecs[i].a);
            preload(3'd2, vecs[i].b);
            preload(vecs[i].rd, vecs[i].pre);
            issue({vecs[i].op, vecs[i].rd, 3'd1, 3'd2}, 1'b0, 1'b0, op_seen);
            check({vecs[i].name, "_aluop"}, op_seen, vecs[i].exp_aluop);
            read_reg(vecs[i].rd, v);
            check({vecs[i].name, "_rd"}, v, vecs[i].exp_rd);
            check({vecs[i].name, "_eq"}, flag_eq, vecs[i].exp_eq);
            check({vecs[i].name, "_lt"}, flag_lt, vecs[i].exp_lt);
        end

        // Preload colliding with writeback at the same address
        preload(3'd1, 8'hF0);
        preload(3'd2, 8'h20);
        issue(enc(4, 3, 1, 2), 1'b1, 1'b0, op_seen);
        read_reg(3'd3, v);
        check("wb_over_preload", v, 8'h10);

        // Preload of rs1 at the decode edge: old value is used
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(enc(4, 4, 1, 2), 1'b0, 1'b1, op_seen);
        read_reg(3'd4, v);
        check("decode_reads_old", v, 8'h08);
        read_reg(3'd1, v);
        check("decode_preload_lands", v, 8'h11);

        // Back-to-back with dependency, valid held high
        preload(3'd1, 8'h09);
        preload(3'd2, 8'h05);
        acc_cyc.delete();
        instr = enc(5, 5, 1, 2);
        instr_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < 1 && n < 20) begin tick(); n++; end
        instr = enc(8, 6, 5, 5);
        n = 0;
        while (acc_cyc.size() < 2 && n < 20) begin tick(); n++; end
        instr_valid = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 4);
        n = 0;
        while (!done && n < 10) begin tick(); n++; end
        check("b2b_done_timeout", done, 1'b1);
        tick();
        read_reg(3'd5, v);
        check("b2b_R5", v, 8'h04);
        read_reg(3'd6, v);
        check("b2b_R6", v, 8'h40);

        // Illegal opcode
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h02);
        preload(3'd7, 8'h3C);
        issue(enc(11, 7, 1, 2), 1'b0, 1'b0, op_seen);
        read_reg(3'd7, v);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        check("illegal_flag", illegal, 1'b1);
        check("illegal_R7", v, 8'h3C);
`else
        check("illegal_flag", illegal, 1'b0);
        check("illegal_R7", v, 8'hFF);
`endif

        // Reset during EXEC aborts the instruction
        preload(3'd1, 8'h01);
        preload(3'd2, 8'h02);
        instr = enc(4, 3, 1, 2);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin tick(); n++; end
        tick();
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        check("abort_idle", instr_ready, 1'b1);
        check("abort_done", done, 1'b0);
        check("abort_illegal_cleared", illegal, 1'b0);
        read_reg(3'd3, v);
        check("abort_R3", v, 8'h00);

        // Randomized run against the model
        model_reset();
        for (int i = 0; i < 8; i++) begin
            v2 = 8'($urandom);
            preload(3'(i), v2);
            m_reg[i] = v2;
        end
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                v2 = 8'($urandom);
                ins[2:0] = 3'($urandom);
                preload(ins[2:0], v2);
                m_reg[ins[2:0]] = v2;
            end
            ins = 13'($urandom);
            if ($urandom_range(0, 3) == 0) ins[2:0] = 3'($urandom_range(0, 7));
            else ins[2:0] = 3'($urandom_range(0, 3));
            issue(ins, 1'b0, 1'b0, op_seen);
            model_exec(ins);
            read_reg(ins[8:6], v);
            check($sformatf("rand%0d_rd", t), v, m_reg[ins[8:6]]);
            check($sformatf("rand%0d_eq", t), flag_eq, m_eq);
            check($sformatf("rand%0d_lt", t), flag_lt, m_lt);
            check($sformatf("rand%0d_ill", t), illegal, m_ill);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            check($sformatf("rand_final_R%0d", i), v, m_reg[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
